// File: rtl/ad100_memory.sv
// ad100 memory responder: shared word RAM for the instruction and data ports, plus an MMIO
// window on the data port holding a 64-bit cycle counter and a byte-wide transmit FIFO.
module ad100_memory #(
  parameter int ADDR_BITS  = 12,
  parameter int FIFO_DEPTH = 8,
  parameter     INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] addr_1,
  output logic [31:0] read_1,
  input  logic [29:0] addr_2,
  output logic [31:0] read_2,
  input  logic [31:0] write_2,
  input  logic        write_enable_2,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [3:0] OFF_CYCLE_LO = 4'd0;
  localparam logic [3:0] OFF_CYCLE_HI = 4'd1;
  localparam logic [3:0] OFF_TXDATA   = 4'd2;
  localparam logic [3:0] OFF_STATUS   = 4'd3;

  logic [31:0]      mem [2**ADDR_BITS];
  logic [7:0]       fifo_buf [FIFO_DEPTH];
  logic [63:0]      cycle;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;
  logic             overflow;

  logic             is_mmio;
  logic [3:0]       mmio_off;
  logic             push, pop, fifo_full, do_push, ovf_clear;
  logic             unused_addr_bits;

  assign is_mmio   = &addr_2[29:4];
  assign mmio_off  = addr_2[3:0];
  assign fifo_full = (count == FULL_CNT);
  assign push      = write_enable_2 && is_mmio && (mmio_off == OFF_TXDATA);
  assign pop       = tx_valid && tx_ready;
  // A pop on the same edge frees the slot, so a push into a full FIFO survives.
  assign do_push   = push && (!fifo_full || pop);
  assign ovf_clear = write_enable_2 && is_mmio && (mmio_off == OFF_STATUS) && write_2[2];

  assign unused_addr_bits = ^addr_1[29:ADDR_BITS];

  assign read_1      = mem[addr_1[ADDR_BITS-1:0]];
  assign tx_valid    = (count != '0);
  assign tx_data     = fifo_buf[rd_ptr];
  assign tx_overflow = overflow;

  always_comb begin
    read_2 = '0;
    if (!is_mmio) begin
      read_2 = mem[addr_2[ADDR_BITS-1:0]];
    end else begin
      case (mmio_off)
        OFF_CYCLE_LO: read_2 = cycle[31:0];
        OFF_CYCLE_HI: read_2 = cycle[63:32];
        OFF_STATUS:   read_2 = {29'b0, overflow, fifo_full, !tx_valid};
        default:      read_2 = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (write_enable_2 && !is_mmio) mem[addr_2[ADDR_BITS-1:0]] <= write_2;
    if (do_push) fifo_buf[wr_ptr] <= write_2[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      cycle <= cycle + 64'd1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_push && !pop) count <= count + 1'b1;
      else if (pop && !do_push) count <= count - 1'b1;
      // Set has priority over clear when both land on the same edge.
      if (push && fifo_full && !pop) overflow <= 1'b1;
      else if (ovf_clear) overflow <= 1'b0;
    end
  end

endmodule
